// File: rtl/bcd2bin4.sv
`default_nettype none
// ============================================================================
//  Module   : bcd2bin4
//  Purpose  : Sequential 4-digit BCD to 14-bit binary converter. It uses
//             reverse double dabble, one shift/correct step per clock, with
//             a start/idle/done handshake.
//  Options  : BCD2BIN_ERR_EN - when defined, digits > 9 are flagged on start.
//             Conversion is then skipped, o_bin=0 and o_err=1.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd2bin4 #(
  parameter int WIDTH = 14
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_bcd3,
  input  logic [3:0]       i_bcd2,
  input  logic [3:0]       i_bcd1,
  input  logic [3:0]       i_bcd0,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_idle,
  output logic             o_done,
  output logic             o_err
);

  // Four decimal digits need exactly 14 result bits and 14 shift steps.
  generate
    if (WIDTH != 14) begin : g_bad_width
      $error("bcd2bin4: WIDTH must be 14");
    end
  endgenerate

  localparam int C_NW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_bcd;
  logic [15:0]       w_bcd_step;
  logic [WIDTH-1:0]  r_bin;
  logic [WIDTH-1:0]  w_bin_step;
  logic [C_NW-1:0]   r_n;
  logic [WIDTH-1:0]  r_bin_out;
  logic              w_bad_digit;

`ifdef BCD2BIN_ERR_EN
  logic              r_err;

  // Any digit outside 0..9 makes the captured value meaningless.
  always_comb begin
    w_bad_digit = (i_bcd3 > 4'd9) || (i_bcd2 > 4'd9) ||
                  (i_bcd1 > 4'd9) || (i_bcd0 > 4'd9);
  end

  assign o_err = r_err;
`else
  assign w_bad_digit = 1'b0;
  assign o_err       = 1'b0;
`endif

  assign o_bin = r_bin_out;

  // One reverse-double-dabble step: shift right, then correct nibbles >= 8 by -3.
  always_comb begin
    w_bcd_step = {1'b0, r_bcd[15:1]};
    w_bin_step = {r_bcd[0], r_bin[WIDTH-1:1]};
    for (int i = 0; i < 4; i++) begin
      if (w_bcd_step[4*i +: 4] >= 4'd8) begin
        w_bcd_step[4*i +: 4] = w_bcd_step[4*i +: 4] - 4'd3;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    o_idle       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_idle = 1'b1;
        if (i_start) begin
          w_state_next = w_bad_digit ? S_DONE : S_CONV;
        end
      end
      S_CONV: begin
        if (r_n == C_NW'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture digits on start, step while converting, and publish the
  // result on the final step so it is valid for the whole DONE cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_n       <= '0;
      r_bin_out <= '0;
`ifdef BCD2BIN_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_bcd <= {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
            r_bin <= '0;
            r_n   <= C_NW'(WIDTH);
`ifdef BCD2BIN_ERR_EN
            r_err <= w_bad_digit;
            if (w_bad_digit) begin
              r_bin_out <= '0;
            end
`endif
          end
        end
        S_CONV: begin
          r_bcd <= w_bcd_step;
          r_bin <= w_bin_step;
          r_n   <= r_n - C_NW'(1);
          if (r_n == C_NW'(1)) begin
            r_bin_out <= w_bin_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd2bin4
//  Purpose  : Scoreboard bench for bcd2bin4. The driver pushes the expected
//             result when a start is accepted. The monitor pops the entry and
//             checks it on each o_done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [3:0]  i_bcd3, i_bcd2, i_bcd1, i_bcd0;
  logic [13:0] o_bin;
  logic        o_idle, o_done, o_err;

  always #5 i_clk = ~i_clk;

  bcd2bin4 #(.WIDTH(14)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_bcd3 (i_bcd3),
    .i_bcd2 (i_bcd2),
    .i_bcd1 (i_bcd1),
    .i_bcd0 (i_bcd0),
    .o_bin  (o_bin),
    .o_idle (o_idle),
    .o_done (o_done),
    .o_err  (o_err)
  );

  typedef struct {
    int bin;
    int err;
    int done_edge;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  int   last_bin = 0;
  bit   idle_due = 1'b0;

  // Posedge counter used to time accepted starts and done pulses.
  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: the decimal value of the digits, or the error outcome.
  function automatic exp_t model(input int a, input int b, input int c, input int d, input int acc);
    exp_t e;
`ifdef BCD2BIN_ERR_EN
    if (a > 9 || b > 9 || c > 9 || d > 9) begin
      e.bin = 0; e.err = 1; e.done_edge = acc;
      return e;
    end
`endif
    e.bin = 1000*a + 100*b + 10*c + d;
    e.err = 0;
    e.done_edge = acc + 14;
    return e;
  endfunction

  // Monitor: checks each done pulse against the scoreboard, then the idle cycle that follows.
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (idle_due) begin
      idle_due = 1'b0;
      check("idle_after_done", {31'd0, o_idle}, 32'd1);
      check("done_single_pulse", {31'd0, o_done}, 32'd0);
      check("bin_held", {18'd0, o_bin}, last_bin);
    end
    if (o_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 bin=%0d (t=%0t)", o_bin, $time);
      end else begin
        e = sb.pop_front();
        check("bin", {18'd0, o_bin}, e.bin);
        check("err", {31'd0, o_err}, e.err);
        check("done_latency_edge", edge_cnt, e.done_edge);
        check("idle_low_in_done", {31'd0, o_idle}, 32'd0);
        last_bin = e.bin;
        idle_due = 1'b1;
      end
    end
  end

  // Drives one cycle of inputs. When the DUT is idle, start is accepted at the
  // next posedge, so the expected result is pushed here.
  task automatic drive(input bit st, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, output bit accepted);
    @(negedge i_clk);
    i_start = st;
    i_bcd3 = a; i_bcd2 = b; i_bcd1 = c; i_bcd0 = d;
    accepted = st && (o_idle === 1'b1) && !i_rst;
    if (accepted) sb.push_back(model(a, b, c, d, edge_cnt + 1));
  endtask

  task automatic start_conv(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      drive(1'b1, a, b, c, d, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL start_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_drain();
    bit acc;
    int n;
    n = 0;
    while ((sb.size() != 0 || o_idle !== 1'b1) && n < 60) begin
      drive(1'b0, i_bcd3, i_bcd2, i_bcd1, i_bcd0, acc);
      n++;
    end
    drive(1'b0, i_bcd3, i_bcd2, i_bcd1, i_bcd0, acc);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic conv(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    bit acc;
    start_conv(a, b, c, d);
    drive(1'b0, a, b, c, d, acc);
    wait_drain();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit acc;
    logic [3:0] a, b, c, d;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_bcd3 = 4'd0; i_bcd2 = 4'd0; i_bcd1 = 4'd0; i_bcd0 = 4'd0;
    repeat (2) @(negedge i_clk);
    check("rst_idle", {31'd0, o_idle}, 32'd1);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_bin", {18'd0, o_bin}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    i_rst = 1'b0;

    // Directed values.
    conv(4'd1, 4'd2, 4'd3, 4'd4);
    check("bin_1234_hex", {18'd0, o_bin}, 32'h04D2);
    conv(4'd9, 4'd9, 4'd9, 4'd9);
    check("bin_9999_hex", {18'd0, o_bin}, 32'h270F);
    conv(4'd0, 4'd0, 4'd0, 4'd0);

    // Start pulses while busy are ignored, and digit changes are not picked up.
    start_conv(4'd1, 4'd2, 4'd3, 4'd4);
    for (int i = 1; i <= 12; i++) begin
      drive((i == 3) || (i == 9), 4'd5, 4'd5, 4'd5, 4'd5, acc);
      if (acc) begin
        checks++;
        failures++;
        $display("FAIL busy_start_accepted actual=1 required=0 cycle=%0d", i);
      end
    end
    wait_drain();

`ifdef BCD2BIN_ERR_EN
    conv(4'd1, 4'hA, 4'd0, 4'd0);
    check("err_flag_held", {31'd0, o_err}, 32'd1);
    conv(4'd0, 4'd0, 4'd4, 4'd2);
    check("err_cleared", {31'd0, o_err}, 32'd0);
`endif

    // Start held high: back-to-back conversions with digits changing every cycle.
    for (int i = 0; i < 70; i++) begin
      a = 4'($urandom_range(9)); b = 4'($urandom_range(9));
      c = 4'($urandom_range(9)); d = 4'($urandom_range(9));
      drive(1'b1, a, b, c, d, acc);
    end
    drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, acc);
    wait_drain();

    // Randomised conversions with idle gaps.
    for (int i = 0; i < 200; i++) begin
      a = 4'($urandom_range(9)); b = 4'($urandom_range(9));
      c = 4'($urandom_range(9)); d = 4'($urandom_range(9));
`ifdef BCD2BIN_ERR_EN
      if ($urandom_range(9) == 0) b = 4'($urandom_range(15, 10));
`endif
      start_conv(a, b, c, d);
      for (int g = 0; g < int'($urandom_range(20)); g++) begin
        drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), acc);
      end
      wait_drain();
    end

    // Reset in the middle of a conversion aborts it without a done pulse.
    start_conv(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (6) drive(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, acc);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_idle", {31'd0, o_idle}, 32'd1);
    check("midrst_done", {31'd0, o_done}, 32'd0);
    check("midrst_bin", {18'd0, o_bin}, 32'd0);
    check("midrst_err", {31'd0, o_err}, 32'd0);
    repeat (3) drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, acc);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (20) drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, acc);
    conv(4'd2, 4'd0, 4'd2, 4'd4);
    check("bin_2024_hex", {18'd0, o_bin}, 32'h07E8);

    repeat (3) drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd2bin4.md
Name: bcd2bin4

Overview:
- Sequential 4-digit BCD-to-binary converter using reverse double dabble (one shift/correct step per clock).
- Inverse of sseg4's binary-to-BCD path. Used to turn digit-entry values (0000-9999) back into a 14-bit binary number.
- Start/idle/done handshake, so it can be chained with sseg4 for round-trip checking.

Parameters:
- WIDTH, 14, binary output width and number of shift iterations. Only 14 is legal; elaboration fails via static assertion otherwise.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_start  input  1  request a conversion; sampled only while o_idle=1
- i_bcd3  input  4  thousands digit
- i_bcd2  input  4  hundreds digit
- i_bcd1  input  4  tens digit
- i_bcd0  input  4  ones digit
- o_bin  output  WIDTH  binary result; held until the next accepted start
- o_idle  output  1  high in IDLE only
- o_done  output  1  one-cycle pulse when o_bin becomes valid
- o_err  output  1  a digit >9 was detected on the last accepted start

Behaviour:
- Reset (async, immediate):
  - state=IDLE; o_bin=0, o_idle=1, o_done=0, o_err=0.
  - Internal bcd_reg=0, bin_reg=0, iteration counter n=0.
- States: IDLE, CONV, DONE.
- IDLE:
  - i_start=1 at a rising edge captures {i_bcd3..i_bcd0} into the 16-bit bcd_reg, clears bin_reg, sets n=WIDTH.
  - If any digit >9 (only with BCD2BIN_ERR_EN): go to DONE with bin_reg=0 and o_err=1.
  - Otherwise: o_err=0, go to CONV.
  - i_start=0: stay in IDLE.
- CONV, once per clock:
  - Shift {bcd_reg,bin_reg} right 1 bit: bcd_reg[0] enters bin_reg[WIDTH-1].
  - Then, on each 4-bit bcd_reg nibble, if nibble>=8 subtract 3 (combinational correct after shift, all nibbles in the same cycle).
  - Decrement n. When n reaches 0 after the step, go to DONE.
  - Exactly 14 clocks are spent in CONV.
- DONE (1 cycle):
  - o_bin<=bin_reg (registered on DONE entry, so valid while o_done=1).
  - o_done=1 for exactly one cycle, then IDLE.
- Latency:
  - Start sampled at edge k; o_done high during the cycle after edge k+14; o_idle high again after edge k+15.
  - Total 15 cycles start-to-done. Error path: o_done after edge k.
- Inputs change during CONV/DONE: ignored, because the digits are captured at start.
- i_start while not idle: ignored. No queueing, no error.
- i_start held high continuously: back-to-back conversions. The next one is accepted on the first IDLE cycle.
- Reset mid-CONV: aborts immediately to reset values; no o_done pulse.
- Arithmetic:
  - Result is the exact unsigned value 1000*d3+100*d2+10*d1+d0, max 9999 = 14'h270F.
  - No overflow is possible for valid digits.
- o_bin and o_err keep their last values through IDLE until the next accepted start.

Optional Feature:
- Macro BCD2BIN_ERR_EN.
- Defined: digit validity check on start as described; invalid input skips CONV, o_bin=0, o_err=1, with o_done at the normal DONE cycle.
- Undefined: no check. Digits >9 are converted as-is through the same algorithm (result unspecified but deterministic). o_err is tied to 0.

Test Plan:
- Reset then start with digits 1,2,3,4 -> o_done 15 cycles after start; o_bin=14'h04D2, o_err=0, o_idle back high one cycle later.
- Digits 9,9,9,9 -> o_bin=14'h270F. Digits 0,0,0,0 -> o_bin=0. Each gives exactly one o_done pulse.
- Exhaustive loop 0..9999: the bench drives sseg4 with i_bin, feeds its BCD outputs into this block, waits for o_done -> o_bin==i_bin for every value.
- Start pulses on cycles 3 and 9 after an accepted start, with the digits changed to 5,5,5,5 -> ignored; result still matches the original digits; single o_done.
- With BCD2BIN_ERR_EN, digits 1,A,0,0 -> o_done the cycle after start, o_err=1, o_bin=0. The next valid start (0,0,4,2) -> o_err=0, o_bin=42.
- Assert i_rst 7 cycles into CONV -> outputs immediately at reset values, no o_done. A fresh start 2,0,2,4 -> o_bin=14'h07E8.
